// File: rtl/reg_bus_pipe.sv
// Register-bus pipeline plus single-outstanding read-response tracker between the
// OCL slave and per-tile component register ports.
// Ports: up_* (OCL side: requests in, read responses out); dn_* (component side:
// retimed requests out, responses in); timeout_cnt/stray_cnt/overlap_err status.
// Latency: requests STAGES cycles, read response 1 cycle. No backpressure anywhere.
module reg_bus_pipe #(
  parameter int          N_IDS    = 16,
  parameter int          STAGES   = 2,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [15:0]         up_waddr,
  input  logic [31:0]         up_wdata,
  input  logic [N_IDS-1:0]    up_wvalid,
  input  logic [15:0]         up_araddr,
  input  logic [N_IDS-1:0]    up_arvalid,
  output logic [N_IDS-1:0]    up_rvalid,
  output logic [N_IDS*32-1:0] up_rdata,
  output logic [15:0]         dn_waddr,
  output logic [31:0]         dn_wdata,
  output logic [N_IDS-1:0]    dn_wvalid,
  output logic [15:0]         dn_araddr,
  output logic [N_IDS-1:0]    dn_arvalid,
  input  logic [N_IDS-1:0]    dn_rvalid,
  input  logic [N_IDS*32-1:0] dn_rdata,
  output logic [15:0]         timeout_cnt,
  output logic [15:0]         stray_cnt,
  output logic                overlap_err
);

  localparam int IW = (N_IDS > 1) ? $clog2(N_IDS) : 1;

  // Request pipeline: plain shift registers, write and read paths independent.
  logic [15:0]      waddr_q  [STAGES];
  logic [31:0]      wdata_q  [STAGES];
  logic [N_IDS-1:0] wvalid_q [STAGES];
  logic [15:0]      araddr_q [STAGES];
  logic [N_IDS-1:0] arvalid_q[STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        waddr_q[i]   <= '0;
        wdata_q[i]   <= '0;
        wvalid_q[i]  <= '0;
        araddr_q[i]  <= '0;
        arvalid_q[i] <= '0;
      end
    end else begin
      waddr_q[0]   <= up_waddr;
      wdata_q[0]   <= up_wdata;
      wvalid_q[0]  <= up_wvalid;
      araddr_q[0]  <= up_araddr;
      arvalid_q[0] <= up_arvalid;
      for (int i = 1; i < STAGES; i++) begin
        waddr_q[i]   <= waddr_q[i-1];
        wdata_q[i]   <= wdata_q[i-1];
        wvalid_q[i]  <= wvalid_q[i-1];
        araddr_q[i]  <= araddr_q[i-1];
        arvalid_q[i] <= arvalid_q[i-1];
      end
    end
  end

  assign dn_waddr   = waddr_q[STAGES-1];
  assign dn_wdata   = wdata_q[STAGES-1];
  assign dn_wvalid  = wvalid_q[STAGES-1];
  assign dn_araddr  = araddr_q[STAGES-1];
  assign dn_arvalid = arvalid_q[STAGES-1];

  // Read tracker
  typedef enum logic {IDLE, PENDING} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  tgt_q, tgt_d, low_idx;
  logic [2:0]     dly_q, dly_d;
  logic           issued_q, issued_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           issuing, live;
  logic [15:0]    cur_cnt;
  logic           rsp_fire, tmo_fire;
  logic [31:0]    rsp_data;
  logic [N_IDS-1:0] tgt_mask, stray_bits;

  // Lowest set index of the incoming read strobe; only that one is tracked.
  always_comb begin
    low_idx = '0;
    for (int i = N_IDS - 1; i >= 0; i--) begin
      if (up_arvalid[i]) low_idx = IW'(i);
    end
  end

  assign tgt_mask = N_IDS'(1) << tgt_q;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dly_d    = dly_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    issuing  = 1'b0;
    live     = 1'b0;
    cur_cnt  = cnt_q;
    rsp_fire = 1'b0;
    tmo_fire = 1'b0;
    rsp_data = ERR_DATA;
    case (state_q)
      IDLE: begin
        if (|up_arvalid) begin
          state_d  = PENDING;
          tgt_d    = low_idx;
          // Counts down to 0 exactly in the cycle the request leaves the pipe.
          dly_d    = 3'(STAGES - 1);
          issued_d = 1'b0;
          cnt_d    = '0;
        end
      end
      PENDING: begin
        issuing = !issued_q && (dly_q == 3'd0);
        live    = issuing || issued_q;
        if (!issued_q && dly_q != 3'd0) dly_d = dly_q - 3'd1;
        // Timer reads 0 in the issue cycle itself.
        cur_cnt = issuing ? 16'd0 : cnt_q;
        if (live) begin
          issued_d = 1'b1;
          cnt_d    = cur_cnt + 16'd1;
        end
        // A response on the expiry cycle takes priority over the timeout.
        if (live && dn_rvalid[tgt_q]) begin
          rsp_fire = 1'b1;
          rsp_data = dn_rdata[tgt_q*32 +: 32];
          state_d  = IDLE;
        end else if (live && cur_cnt == 16'(TIMEOUT)) begin
          rsp_fire = 1'b1;
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Anything in IDLE, or any bit other than the tracked target, is dropped.
  assign stray_bits = (state_q == IDLE) ? dn_rvalid : (dn_rvalid & ~tgt_mask);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      dly_q       <= '0;
      issued_q    <= 1'b0;
      cnt_q       <= '0;
      up_rvalid   <= '0;
      up_rdata    <= '0;
      timeout_cnt <= '0;
      stray_cnt   <= '0;
      overlap_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dly_q    <= dly_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      up_rvalid <= rsp_fire ? tgt_mask : '0;
      if (rsp_fire) up_rdata[tgt_q*32 +: 32] <= rsp_data;
      if (tmo_fire && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      if ((|stray_bits) && stray_cnt != 16'hFFFF) stray_cnt <= stray_cnt + 16'd1;
      if (state_q == PENDING && (|up_arvalid)) overlap_err <= 1'b1;
    end
  end

endmodule
